// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetcher feeding a small FIFO queue.
//
// Ports
//   clk            single clock, all state changes on its rising edge
//   rst            synchronous active-high reset
//   fetch_en       permits fetching when high
//   redirect_valid flush the queue and restart fetch at redirect_pc
//   redirect_pc    restart byte address (low two bits ignored)
//   imem_addr      byte address to the instruction ROM (the PC itself)
//   imem_rdata     ROM word at imem_addr, same-cycle combinational read
//   out_valid      queue head is presented
//   out_ready      consumer accepts the head entry
//   out_instr      head instruction (0 when the queue is empty)
//   out_pc         head instruction address (0 when the queue is empty)
//   count          current queue occupancy
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fetch_en,
  input  logic                         redirect_valid,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc,
  output logic [ADDR_WIDTH-1:0]        imem_addr,
  input  logic [31:0]                  imem_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_instr,
  output logic [ADDR_WIDTH-1:0]        out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];
  logic [31:0]           instr_mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      cnt;
  logic                  empty;
  logic                  full;
  logic                  deq;
  logic                  fetch;

  // Handshake decode; a redirect suppresses both dequeue and fetch.
  always_comb begin
    empty     = (cnt == '0);
    full      = (cnt == CNT_W'(DEPTH));
    out_valid = !empty && !redirect_valid;
    deq       = out_valid && out_ready;
    fetch     = fetch_en && !redirect_valid && (!full || deq);
  end

  assign imem_addr = pc;
  assign count     = cnt;
  assign out_pc    = empty ? '0 : pc_mem[head];
  assign out_instr = empty ? '0 : instr_mem[head];

  // PC, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc   <= ADDR_WIDTH'(RESET_PC);
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (redirect_valid) begin
      pc   <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (fetch) begin
        pc   <= pc + ADDR_WIDTH'(4);
        tail <= tail + PTR_W'(1);
      end
      if (deq) begin
        head <= head + PTR_W'(1);
      end
      case ({fetch, deq})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Queue storage is intentionally not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (!rst && fetch) begin
      pc_mem[tail]    <= pc;
      instr_mem[tail] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (ADDR_WIDTH=12, DEPTH=4, RESET_PC=0).
module tb_fetch_unit;

  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_en;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_pc;
  logic [2:0]    count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // ROM contents: a recognisable word derived from its address.
  function automatic logic [31:0] rom(input logic [AW-1:0] a);
    return {8'hC3, 4'h0, a, 8'h5A} ^ {a[7:0], 24'h0};
  endfunction

  assign imem_rdata = rom(imem_addr);

  fetch_unit #(.ADDR_WIDTH(AW), .DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .count(count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0; #1;
  endtask

  task automatic test_reset();
    fetch_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    do_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", out_instr); end
    n_cmp++; if (out_pc !== 12'h000) begin n_err++; $display("FAIL reset_pc got %h want 000", out_pc); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (imem_addr !== 12'h000) begin n_err++; $display("FAIL reset_addr got %h want 000", imem_addr); end
  endtask

  task automatic test_streaming();
    logic [AW-1:0] exp_pc;
    fetch_en = 1'b1; out_ready = 1'b1;
    do_reset();
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL stream_c0_count got %0d want 0", count); end
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_pc = AW'(4 * i);
      n_cmp++; if (out_pc !== exp_pc) begin n_err++; $display("FAIL stream_pc[%0d] got %h want %h", i, out_pc, exp_pc); end
      n_cmp++; if (out_instr !== rom(exp_pc)) begin n_err++; $display("FAIL stream_instr[%0d] got %h want %h", i, out_instr, rom(exp_pc)); end
      n_cmp++; if (count !== 3'd1 || out_valid !== 1'b1) begin n_err++; $display("FAIL stream_cnt[%0d] got %0d/%b want 1/1", i, count, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    fetch_en = 1'b1; out_ready = 1'b0;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_cmp++; if (count !== 3'(i)) begin n_err++; $display("FAIL bp_count[%0d] got %0d want %0d", i, count, i); end
    end
    n_cmp++; if (imem_addr !== 12'h010) begin n_err++; $display("FAIL bp_addr got %h want 010", imem_addr); end
    n_cmp++; if (out_pc !== 12'h000) begin n_err++; $display("FAIL bp_head got %h want 000", out_pc); end
    tick();
    n_cmp++; if (count !== 3'd4 || imem_addr !== 12'h010) begin n_err++; $display("FAIL full_hold got %0d/%h want 4/010", count, imem_addr); end
  endtask

  task automatic test_full_dequeue();
    out_ready = 1'b1; #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fulldq_valid got %b want 1", out_valid); end
    tick();
    out_ready = 1'b0; #1;
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fulldq_count got %0d want 4", count); end
    n_cmp++; if (out_pc !== 12'h004) begin n_err++; $display("FAIL fulldq_head got %h want 004", out_pc); end
    n_cmp++; if (imem_addr !== 12'h014) begin n_err++; $display("FAIL fulldq_addr got %h want 014", imem_addr); end
  endtask

  task automatic test_drain();
    logic [AW-1:0] exp_pc;
    fetch_en = 1'b0; out_ready = 1'b1; #1;
    // Queue holds 004, 008, 00C, 010; tail pointer has already wrapped.
    for (int i = 0; i < 4; i++) begin
      exp_pc = AW'(4 + 4 * i);
      n_cmp++; if (out_pc !== exp_pc || out_instr !== rom(exp_pc)) begin n_err++; $display("FAIL drain_head[%0d] got %h/%h want %h/%h", i, out_pc, out_instr, exp_pc, rom(exp_pc)); end
      n_cmp++; if (count !== 3'(4 - i)) begin n_err++; $display("FAIL drain_count[%0d] got %0d want %0d", i, count, 4 - i); end
      tick();
    end
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got %0d/%b want 0/0", count, out_valid); end
    n_cmp++; if (out_pc !== 12'h000 || out_instr !== 32'h0) begin n_err++; $display("FAIL drain_zero got %h/%h want 000/0", out_pc, out_instr); end
    tick();
    n_cmp++; if (count !== 3'd0 || imem_addr !== 12'h014) begin n_err++; $display("FAIL empty_hold got %0d/%h want 0/014", count, imem_addr); end
  endtask

  task automatic test_redirect();
    fetch_en = 1'b1; out_ready = 1'b0;
    do_reset();
    tick(); tick(); tick();
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL redir_pre got %0d want 3", count); end
    redirect_valid = 1'b1; redirect_pc = 12'h023; out_ready = 1'b1; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid got %b want 0", out_valid); end
    tick();
    redirect_valid = 1'b0; out_ready = 1'b0; #1;
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush got %0d/%b want 0/0", count, out_valid); end
    n_cmp++; if (imem_addr !== 12'h020) begin n_err++; $display("FAIL redir_addr got %h want 020", imem_addr); end
    tick();
    n_cmp++; if (out_pc !== 12'h020 || count !== 3'd1) begin n_err++; $display("FAIL redir_first got %h/%0d want 020/1", out_pc, count); end
    n_cmp++; if (out_instr !== rom(12'h020)) begin n_err++; $display("FAIL redir_instr got %h want %h", out_instr, rom(12'h020)); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 12'hFFC; out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; #1;
    n_cmp++; if (imem_addr !== 12'hFFC || count !== 3'd0) begin n_err++; $display("FAIL wrap_addr got %h/%0d want FFC/0", imem_addr, count); end
    tick();
    n_cmp++; if (out_pc !== 12'hFFC || imem_addr !== 12'h000) begin n_err++; $display("FAIL wrap_first got %h/%h want FFC/000", out_pc, imem_addr); end
    tick();
    n_cmp++; if (out_pc !== 12'h000 || out_instr !== rom(12'h000)) begin n_err++; $display("FAIL wrap_second got %h/%h want 000/%h", out_pc, out_instr, rom(12'h000)); end
  endtask

  task automatic test_midrun_reset();
    out_ready = 1'b0; fetch_en = 1'b1;
    tick(); tick(); tick(); tick();
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL mid_full got %0d want 4", count); end
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 12'h100; out_ready = 1'b1;
    tick();
    rst = 1'b0; redirect_valid = 1'b0; fetch_en = 1'b0; #1;
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL mid_flush got %0d/%b want 0/0", count, out_valid); end
    n_cmp++; if (imem_addr !== 12'h000) begin n_err++; $display("FAIL mid_addr got %h want 000", imem_addr); end
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_full_dequeue();
    test_drain();
    test_redirect();
    test_wrap();
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, meaning the PC and instruction memory byte-address width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the fetch queue entry count (power of two, at least 2).
REQ-003 The block SHALL have parameter RESET_PC, default 0, meaning the PC loaded on reset (word aligned).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 The block SHALL have port fetch_en, input, 1, which permits fetching when high.
REQ-007 The block SHALL have port redirect_valid, input, 1, a request to flush and restart fetch.
REQ-008 The block SHALL have port redirect_pc, input, ADDR_WIDTH, the restart address.
REQ-009 The block SHALL have port imem_addr, output, ADDR_WIDTH, the byte address to the instruction ROM.
REQ-010 The block SHALL have port imem_rdata, input, 32, the ROM word at imem_addr, combinational same-cycle read, byte at addr in bits 31:24.
REQ-011 The block SHALL have port out_valid, output, 1, which means the queue head is presented.
REQ-012 The block SHALL have port out_ready, input, 1, the consumer's acceptance of the head entry.
REQ-013 The block SHALL have port out_instr, output, 32, the head instruction.
REQ-014 The block SHALL have port out_pc, output, ADDR_WIDTH, the head instruction address.
REQ-015 The block SHALL have port count, output, clog2(DEPTH+1), the current queue occupancy.

Function
REQ-016 The block SHALL drive imem_addr directly from the internal PC register, with no added latency.
REQ-017 The block SHALL define a dequeue as a cycle in which out_valid and out_ready are both high.
REQ-018 The block SHALL define a fetch as a cycle in which fetch_en is high, redirect_valid is low, and either count is below DEPTH or a dequeue occurs that cycle.
REQ-019 On a fetch, the block SHALL write {PC, imem_rdata} into the tail entry at the clock edge and advance PC by 4, modulo 2^ADDR_WIDTH (wrap from all-ones-minus-3 to 0).
REQ-020 Without a fetch, PC SHALL hold and no entry SHALL be written.
REQ-021 out_valid SHALL be (count != 0) and not redirect_valid.
REQ-022 out_instr and out_pc SHALL present the head entry when count != 0, and SHALL be 0 when count == 0.
REQ-023 Fetch-to-output latency SHALL be one cycle: a word fetched at edge t is visible at the head from cycle t+1 when the queue was empty.
REQ-024 The block SHALL update count as +1 on fetch only, -1 on dequeue only, and unchanged on both or neither.
REQ-025 Full boundary: at count == DEPTH with a dequeue, fetch SHALL proceed and count SHALL stay at DEPTH.
REQ-026 Full boundary: at count == DEPTH with no dequeue, no fetch SHALL occur.
REQ-027 Empty boundary: at count == 0, no dequeue SHALL occur, regardless of out_ready.
REQ-028 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-029 The queue SHALL preserve FIFO order.
REQ-030 On redirect_valid, at the next edge the block SHALL set count, head and tail to 0, load PC with {redirect_pc[ADDR_WIDTH-1:2], 2'b00}, and enqueue nothing.
REQ-031 In a redirect cycle, out_ready SHALL be ignored and no dequeue SHALL occur.
REQ-032 Redirect SHALL take priority over fetch, dequeue and fetch_en.
REQ-033 After a redirect, the first fetch SHALL occur in the following cycle if fetch_en is high.
REQ-034 Deasserting fetch_en SHALL stop fetching but still allow draining of queued entries.

Reset
REQ-035 While rst is high at an edge, the block SHALL load PC with RESET_PC and set count, head and tail to 0.
REQ-036 Reset SHALL override redirect_valid, fetch and dequeue.
REQ-037 Out of reset, outputs SHALL be: out_valid 0, out_instr 0, out_pc 0, count 0, imem_addr = RESET_PC.
REQ-038 Reset asserted mid-operation SHALL discard all queued entries at that edge.
REQ-039 Queue storage contents need not be cleared on reset.

Verification
REQ-040 Streaming case: after reset release with fetch_en=1 and out_ready=1 held, the bench SHALL see out_pc 0, 4, 8, ... on consecutive cycles from cycle 1, each out_instr matching the ROM word, with count steady at 1.
REQ-041 Backpressure case: with out_ready=0 and fetch_en=1, the bench SHALL see count reach DEPTH=4 after 4 cycles, imem_addr hold at 0x010, and head out_pc 0x000.
REQ-042 Simultaneous full case: then raising out_ready for one cycle, the bench SHALL see count stay at 4, head out_pc become 0x004, and imem_addr become 0x014.
REQ-043 Redirect case: with 3 entries queued and redirect_valid=1, redirect_pc=0x023, the bench SHALL see out_valid 0 in that cycle, count 0 and imem_addr 0x020 next cycle, and out_pc 0x020 the cycle after.
REQ-044 Wrap case: after a redirect to 0xFFC with ADDR_WIDTH=12, the bench SHALL see out_pc sequence 0xFFC then 0x000.
REQ-045 Mid-run reset case: asserting rst for one cycle with a full queue and a redirect pending, the bench SHALL see count 0, out_valid 0, and imem_addr = RESET_PC next cycle.
